instr_mem_responder: RTL and testbench

- Responder end of the instruction-fetch bus (req/gnt/addr/rdata/err/rvalid) that the fetch stage drives as initiator.
- Grants requests, reads a synchronous word-wide instruction RAM, and returns data or an error after a fixed, parameterised latency.
- Tracks and bounds outstanding transactions.
- Sits between the core's fetch port and the instruction RAM macro; serves as both the SoC instruction memory front end and the bench memory model.

---
 rtl/instr_mem_pkg.sv | 26 ++
 rtl/instr_mem_delay_line.sv | 62 ++++++
 rtl/instr_mem_responder.sv | 130 +++++++++++++
 tb/tb_instr_mem_responder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Contents:
//   instr_rsp_t  - one response beat (data word plus error flag)
//   LFSR_*       - seed/taps of the optional grant-throttle LFSR
//   *_MIN/*_MAX  - legal ranges for the responder parameters
//   lfsr_next()  - one step of the throttle LFSR
package instr_mem_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } instr_rsp_t;

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form: taps on bits 7, 5, 4, 3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int unsigned LATENCY_MAX         = 7;
    localparam int unsigned MAX_OUTSTANDING_MIN = 1;
    localparam int unsigned MAX_OUTSTANDING_MAX = 8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] state);
        return {state[6:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/instr_mem_delay_line.sv
// Fixed-depth delay for response beats (valid + instr_rsp_t).
// Ports:
//   clk, rstn          - clock, asynchronous active-low reset (clears all valid bits)
//   valid_i/rdata_i/err_i - beat entering the line
//   valid_o/rdata_o/err_o - beat leaving the line DEPTH cycles later
// DEPTH = 0 makes the line a combinational pass-through.
module instr_mem_delay_line
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid_i,
    input  logic [31:0] rdata_i,
    input  logic        err_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rstn;

        assign valid_o = valid_i;
        assign rdata_o = rdata_i;
        assign err_o   = err_i;
    end else begin : g_shift
        logic [DEPTH-1:0] valid_q, valid_d;
        instr_rsp_t       rsp_q [DEPTH];
        instr_rsp_t       rsp_d [DEPTH];

        always_comb begin
            valid_d[0] = valid_i;
            rsp_d[0]   = '{rdata: rdata_i, err: err_i};
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_d[i] = valid_q[i-1];
                rsp_d[i]   = rsp_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                valid_q <= '0;
                for (int i = 0; i < int'(DEPTH); i++) begin
                    rsp_q[i] <= '0;
                end
            end else begin
                valid_q <= valid_d;
                for (int i = 0; i < int'(DEPTH); i++) begin
                    rsp_q[i] <= rsp_d[i];
                end
            end
        end

        assign valid_o = valid_q[DEPTH-1];
        assign rdata_o = rsp_q[DEPTH-1].rdata;
        assign err_o   = rsp_q[DEPTH-1].err;
    end

endmodule

// File: rtl/instr_mem_responder.sv
// Responder side of the instruction-fetch bus in front of a synchronous word RAM.
// Grants requests, reads the RAM, and returns data (or an error for out-of-range
// addresses) 1+LATENCY cycles after the accepting cycle, strictly in grant order.
// Ports:
//   clk, rstn                  - clock, asynchronous active-low reset
//   instr_req_i, instr_addr_i  - fetch request and byte address
//   instr_gnt_o                - request accepted this cycle
//   instr_rvalid_o/rdata_o/err_o - response beat (data/err are 0 when rvalid is 0)
//   mem_en_o, mem_addr_o       - RAM read enable and word address
//   mem_rdata_i                - RAM data, valid the cycle after mem_en_o
// Parameters: MEM_WORDS (RAM depth), LATENCY (0..7), MAX_OUTSTANDING (1..8).
// Optional macro INSTR_MEM_GNT_THROTTLE_EN: withholds grants pseudo-randomly using
// an 8-bit LFSR seeded from reset.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned LATENCY         = 0,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         instr_req_i,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_gnt_o,
    output logic [31:0]                  instr_rdata_o,
    output logic                         instr_err_o,
    output logic                         instr_rvalid_o,
    output logic                         mem_en_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    input  logic [31:0]                  mem_rdata_i
);

    localparam int unsigned AW    = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    logic             in_range;
    logic             accept;
    logic             retire;
    logic             slot_free;
    logic             gnt_allow;
    logic [CNT_W-1:0] count_q, count_d;

    // Beat in the RAM read cycle (one cycle after acceptance).
    logic             rd_valid_q, rd_valid_d;
    logic             rd_err_q, rd_err_d;
    logic [31:0]      rd_rdata;

    logic             dl_valid;
    logic [31:0]      dl_rdata;
    logic             dl_err;

    assign in_range = ({1'b0, instr_addr_i} < ADDR_LIMIT);

`ifdef INSTR_MEM_GNT_THROTTLE_EN
    logic [7:0] lfsr_q, lfsr_d;

    assign lfsr_d    = lfsr_next(lfsr_q);
    assign gnt_allow = lfsr_q[0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign gnt_allow = 1'b1;
`endif

    // A slot freed by the response leaving this cycle may be reused in the same
    // cycle, which is what lets MAX_OUTSTANDING >= LATENCY+1 run at full rate.
    assign retire      = dl_valid;
    assign slot_free   = (count_q < CNT_W'(MAX_OUTSTANDING)) | retire;
    assign instr_gnt_o = instr_req_i & slot_free & gnt_allow;
    assign accept      = instr_gnt_o;

    // addr[1:0] ignored: a halfword-aligned PC reads its containing word.
    assign mem_en_o   = accept & in_range;
    assign mem_addr_o = instr_addr_i[AW+1:2];

    always_comb begin
        rd_valid_d = accept;
        rd_err_d   = accept & ~in_range;
    end

    // Out-of-range beats never enabled the RAM, so its output is masked to 0.
    assign rd_rdata = (rd_valid_q & ~rd_err_q) ? mem_rdata_i : 32'h0;

    always_comb begin
        count_d = count_q;
        unique case ({accept, retire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
        end
    end

    instr_mem_delay_line #(
        .DEPTH (LATENCY)
    ) u_delay_line (
        .clk     (clk),
        .rstn    (rstn),
        .valid_i (rd_valid_q),
        .rdata_i (rd_rdata),
        .err_i   (rd_err_q),
        .valid_o (dl_valid),
        .rdata_o (dl_rdata),
        .err_o   (dl_err)
    );

    assign instr_rvalid_o = dl_valid;
    assign instr_rdata_o  = dl_valid ? dl_rdata : 32'h0;
    assign instr_err_o    = dl_valid & dl_err;

endmodule

// File: tb/tb_instr_mem_responder.sv
module tb_instr_mem_responder;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // Instance A: LATENCY=0, MAX_OUTSTANDING=2
    logic        req_a = 1'b0;
    logic [31:0] addr_a = '0;
    logic        gnt_a, err_a, rvalid_a, men_a;
    logic [31:0] rdata_a;
    logic [9:0]  maddr_a;
    logic [31:0] mrdata_a = '0;

    // Instance B: LATENCY=2, MAX_OUTSTANDING=2
    logic        req_b = 1'b0;
    logic [31:0] addr_b = '0;
    logic        gnt_b, err_b, rvalid_b, men_b;
    logic [31:0] rdata_b;
    logic [9:0]  maddr_b;
    logic [31:0] mrdata_b = '0;

    instr_mem_responder #(
        .MEM_WORDS       (1024),
        .LATENCY         (0),
        .MAX_OUTSTANDING (2)
    ) u_dut_a (
        .clk            (clk),
        .rstn           (rstn),
        .instr_req_i    (req_a),
        .instr_addr_i   (addr_a),
        .instr_gnt_o    (gnt_a),
        .instr_rdata_o  (rdata_a),
        .instr_err_o    (err_a),
        .instr_rvalid_o (rvalid_a),
        .mem_en_o       (men_a),
        .mem_addr_o     (maddr_a),
        .mem_rdata_i    (mrdata_a)
    );

    instr_mem_responder #(
        .MEM_WORDS       (1024),
        .LATENCY         (2),
        .MAX_OUTSTANDING (2)
    ) u_dut_b (
        .clk            (clk),
        .rstn           (rstn),
        .instr_req_i    (req_b),
        .instr_addr_i   (addr_b),
        .instr_gnt_o    (gnt_b),
        .instr_rdata_o  (rdata_b),
        .instr_err_o    (err_b),
        .instr_rvalid_o (rvalid_b),
        .mem_en_o       (men_b),
        .mem_addr_o     (maddr_b),
        .mem_rdata_i    (mrdata_b)
    );

    // RAM contents: word 0x10 holds an ADDI, every other word encodes its index.
    function automatic logic [31:0] ram_word(input logic [9:0] idx);
        return (idx == 10'h010) ? 32'h0050_0093 : (32'hB000_0000 | 32'(idx));
    endfunction

    always @(posedge clk) begin
        if (men_a) mrdata_a <= ram_word(maddr_a);
        if (men_b) mrdata_b <= ram_word(maddr_b);
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        exp_en;
        logic [9:0]  exp_maddr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    // Expectations for the LATENCY=2 back-to-back sequence, cycles 0..6.
    logic [31:0] seq_addr  [7];
    logic        seq_req   [7];
    logic        seq_gnt   [7];
    logic        seq_rv    [7];
    logic [31:0] seq_rdata [7];

`ifdef INSTR_MEM_GNT_THROTTLE_EN
    logic [7:0]  lfsr_m;
    logic        exp_v [80];
    logic [31:0] exp_d [80];
    int          cnt_m;
    logic        ret_m, gnt_m;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0040, 1'b1, 10'h010, 32'h0050_0093, 1'b0};
        vecs[1] = '{32'h0000_0042, 1'b1, 10'h010, 32'h0050_0093, 1'b0};
        vecs[2] = '{32'h0000_0044, 1'b1, 10'h011, 32'hB000_0011, 1'b0};
        vecs[3] = '{32'h0000_0FFC, 1'b1, 10'h3FF, 32'hB000_03FF, 1'b0};
        vecs[4] = '{32'h0000_1000, 1'b0, 10'h000, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'hFFFF_FFFC, 1'b0, 10'h000, 32'h0000_0000, 1'b1};
        vecs[6] = '{32'h0000_0000, 1'b1, 10'h000, 32'hB000_0000, 1'b0};

        seq_addr  = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h0, 32'h0, 32'h0};
        seq_req   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        seq_gnt   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        seq_rv    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        seq_rdata = '{32'h0, 32'h0, 32'h0, 32'hB000_0000, 32'hB000_0001, 32'h0, 32'hB000_0002};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_rvalid_a", 32'(rvalid_a), 32'h0);
        check("rst_rdata_a", rdata_a, 32'h0);
        check("rst_err_a", 32'(err_a), 32'h0);
        check("rst_men_a", 32'(men_a), 32'h0);
        check("rst_gnt_a", 32'(gnt_a), 32'h0);
        check("rst_rvalid_b", 32'(rvalid_b), 32'h0);
        check("rst_men_b", 32'(men_b), 32'h0);
        @(negedge clk);
        rstn = 1'b1;

`ifndef INSTR_MEM_GNT_THROTTLE_EN
        // Single isolated requests, LATENCY=0
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            req_a  = 1'b1;
            addr_a = vecs[i].addr;
            #1;
            check($sformatf("v%0d_gnt", i), 32'(gnt_a), 32'h1);
            check($sformatf("v%0d_men", i), 32'(men_a), 32'(vecs[i].exp_en));
            if (vecs[i].exp_en) check($sformatf("v%0d_maddr", i), 32'(maddr_a),
                                      32'(vecs[i].exp_maddr));
            @(negedge clk);
            req_a  = 1'b0;
            addr_a = '0;
            #1;
            check($sformatf("v%0d_rvalid", i), 32'(rvalid_a), 32'h1);
            check($sformatf("v%0d_rdata", i), rdata_a, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), 32'(err_a), 32'(vecs[i].exp_err));
            @(negedge clk);
            #1;
            check($sformatf("v%0d_idle_rvalid", i), 32'(rvalid_a), 32'h0);
            check($sformatf("v%0d_idle_rdata", i), rdata_a, 32'h0);
            check($sformatf("v%0d_idle_err", i), 32'(err_a), 32'h0);
        end

        // Full-rate streaming, LATENCY=0
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_a  = (k < 4);
            addr_a = 32'(k) * 32'd4;
            #1;
            if (k < 4) check($sformatf("stream%0d_gnt", k), 32'(gnt_a), 32'h1);
            if (k > 0) begin
                check($sformatf("stream%0d_rvalid", k), 32'(rvalid_a), 32'h1);
                check($sformatf("stream%0d_rdata", k), rdata_a, ram_word(10'(k - 1)));
            end
        end
        @(negedge clk);
        #1;
        check("stream_end_rvalid", 32'(rvalid_a), 32'h0);

        // LATENCY=2 outstanding limit and ordering
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            req_b  = seq_req[c];
            addr_b = seq_addr[c];
            #1;
            check($sformatf("lim_c%0d_gnt", c), 32'(gnt_b), 32'(seq_gnt[c]));
            check($sformatf("lim_c%0d_rvalid", c), 32'(rvalid_b), 32'(seq_rv[c]));
            check($sformatf("lim_c%0d_rdata", c), rdata_b, seq_rdata[c]);
        end
        @(negedge clk);
        #1;
        check("lim_end_rvalid", 32'(rvalid_b), 32'h0);

        // LATENCY=2 out-of-range followed by in-range
        @(negedge clk);
        req_b = 1'b1; addr_b = 32'h0000_1000;
        #1;
        check("oor_gnt", 32'(gnt_b), 32'h1);
        check("oor_men", 32'(men_b), 32'h0);
        @(negedge clk);
        addr_b = 32'h0000_0040;
        #1;
        check("oor_next_gnt", 32'(gnt_b), 32'h1);
        check("oor_next_men", 32'(men_b), 32'h1);
        check("oor_next_maddr", 32'(maddr_b), 32'h10);
        @(negedge clk);
        req_b = 1'b0; addr_b = '0;
        #1;
        check("oor_c2_rvalid", 32'(rvalid_b), 32'h0);
        @(negedge clk);
        #1;
        check("oor_c3_rvalid", 32'(rvalid_b), 32'h1);
        check("oor_c3_err", 32'(err_b), 32'h1);
        check("oor_c3_rdata", rdata_b, 32'h0);
        @(negedge clk);
        #1;
        check("oor_c4_rvalid", 32'(rvalid_b), 32'h1);
        check("oor_c4_err", 32'(err_b), 32'h0);
        check("oor_c4_rdata", rdata_b, 32'h0050_0093);
        @(negedge clk);
        #1;
        check("oor_c5_rvalid", 32'(rvalid_b), 32'h0);

        // Reset with two responses in flight, LATENCY=2
        @(negedge clk);
        req_b = 1'b1; addr_b = 32'h0;
        #1;
        check("rif_c0_gnt", 32'(gnt_b), 32'h1);
        @(negedge clk);
        addr_b = 32'h4;
        #1;
        check("rif_c1_gnt", 32'(gnt_b), 32'h1);
        @(negedge clk);
        req_b = 1'b0;
        rstn  = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("rif_drop%0d_rvalid", c), 32'(rvalid_b), 32'h0);
            @(negedge clk);
        end
        // Counter is back at 0: exactly two grants before the limit.
        req_b = 1'b1; addr_b = 32'h0;
        #1;
        check("rif_new0_gnt", 32'(gnt_b), 32'h1);
        @(negedge clk);
        addr_b = 32'h4;
        #1;
        check("rif_new1_gnt", 32'(gnt_b), 32'h1);
        @(negedge clk);
        addr_b = 32'h8;
        #1;
        check("rif_new2_gnt", 32'(gnt_b), 32'h0);
        @(negedge clk);
        req_b = 1'b0;
        #1;
        check("rif_rsp0_rvalid", 32'(rvalid_b), 32'h1);
        check("rif_rsp0_rdata", rdata_b, 32'hB000_0000);
        @(negedge clk);
        #1;
        check("rif_rsp1_rvalid", 32'(rvalid_b), 32'h1);
        check("rif_rsp1_rdata", rdata_b, 32'hB000_0001);
        @(negedge clk);
        #1;
        check("rif_end_rvalid", 32'(rvalid_b), 32'h0);
`else
        // Throttled grants on the LATENCY=2 instance against a reference LFSR.
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn   = 1'b1;
        lfsr_m = 8'hA5;
        cnt_m  = 0;
        for (int i = 0; i < 80; i++) begin
            exp_v[i] = 1'b0;
            exp_d[i] = '0;
        end
        for (int k = 0; k < 70; k++) begin
            if (k > 0) @(negedge clk);
            req_b  = (k < 64);
            addr_b = 32'(k) * 32'd4;
            #1;
            ret_m = exp_v[k];
            gnt_m = req_b & lfsr_m[0] & ((cnt_m < 2) | ret_m);
            check($sformatf("thr%0d_gnt", k), 32'(gnt_b), 32'(gnt_m));
            check($sformatf("thr%0d_rvalid", k), 32'(rvalid_b), 32'(ret_m));
            if (ret_m) check($sformatf("thr%0d_rdata", k), rdata_b, exp_d[k]);
            if (gnt_m) begin
                exp_v[k+3] = 1'b1;
                exp_d[k+3] = ram_word(10'(k));
            end
            cnt_m  = cnt_m + int'(gnt_m) - int'(ret_m);
            lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
